// File: rtl/ultrasound_pkg.sv
// Shared state encodings and default parameter values for the ultrasound scanner.
// Purely declarative: no logic, no latency, no flow control.
package ultrasound_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_POWER     = 3'd1,
        S_TRIGGER   = 3'd2,
        S_WAIT_ECHO = 3'd3,
        S_MEASURE   = 3'd4,
        S_STORE     = 3'd5,
        S_NEXT      = 3'd6,
        S_REPORT    = 3'd7
    } state_e;

    localparam int DEF_NUM_CH         = 10;
    localparam int DEF_NUM_SAMPLES    = 3;
    localparam int DEF_DIST_W         = 8;
    localparam int DEF_TRIG_CYCLES    = 5;
    localparam int DEF_SETTLE_CYCLES  = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/ultrasound_array_scanner_if.sv
// Scanner control/sensor bundle; master = controller side, slave = scanner.
// Plain wires, no latency; the start pulse is only honoured while the scanner is idle.
interface ultrasound_array_scanner_if #(
    parameter int NUM_CH = ultrasound_pkg::DEF_NUM_CH,
    parameter int DIST_W = ultrasound_pkg::DEF_DIST_W
);
    localparam int CH_W = $clog2(NUM_CH);

    logic                     calculate;
    logic [NUM_CH-1:0]        channel_mask;
    logic [NUM_CH-1:0]        ultrasound_signals;
    logic [NUM_CH-1:0]        ultrasound_commands;
    logic [NUM_CH-1:0]        ultrasound_power;
    logic [CH_W+DIST_W-1:0]   rover_location;
    logic                     valid_location;
    logic                     done;
    logic                     busy;
    logic [2:0]               state;

    modport master (
        output calculate, channel_mask, ultrasound_signals,
        input  ultrasound_commands, ultrasound_power, rover_location,
               valid_location, done, busy, state
    );

    modport slave (
        input  calculate, channel_mask, ultrasound_signals,
        output ultrasound_commands, ultrasound_power, rover_location,
               valid_location, done, busy, state
    );

endinterface

// File: rtl/ultrasound_median_sorter.sv
// Insertion-sorted sample buffer; an insert is visible in the sorted array and median the next cycle.
// No backpressure: inserts beyond NUM_SAMPLES are dropped.
module ultrasound_median_sorter #(
    parameter int NUM_SAMPLES = 3,
    parameter int DIST_W      = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              insert_i,
    input  logic [DIST_W-1:0] sample_i,
    output logic [DIST_W-1:0] median_o
);
    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

    logic [DIST_W-1:0]      sbuf_q [NUM_SAMPLES];
    logic [DIST_W-1:0]      sbuf_d [NUM_SAMPLES];
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_SAMPLES-1:0] stay;

    always_comb begin
        sbuf_d = sbuf_q;
        cnt_d  = cnt_q;
        stay   = '0;
        for (int i = 0; i < NUM_SAMPLES; i++) begin
            stay[i] = (i < int'(cnt_q)) && (sbuf_q[i] <= sample_i);
        end
        if (clear_i) begin
            for (int i = 0; i < NUM_SAMPLES; i++) sbuf_d[i] = '0;
            cnt_d = '0;
        end else if (insert_i && (int'(cnt_q) < NUM_SAMPLES)) begin
            // stay[] is a prefix mask: entries <= sample keep place, the rest shift up one slot
            sbuf_d[0] = stay[0] ? sbuf_q[0] : sample_i;
            for (int i = 1; i < NUM_SAMPLES; i++) begin
                sbuf_d[i] = stay[i] ? sbuf_q[i] : (stay[i-1] ? sample_i : sbuf_q[i-1]);
            end
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SAMPLES; i++) sbuf_q[i] <= '0;
            cnt_q <= '0;
        end else begin
            sbuf_q <= sbuf_d;
            cnt_q  <= cnt_d;
        end
    end

    assign median_o = sbuf_q[NUM_SAMPLES/2];

endmodule

// File: rtl/ultrasound_array_scanner.sv
// Scans enabled ultrasound channels, takes a median echo distance per channel, reports the closest.
// Multi-cycle scan; calculate is ignored while busy, all outputs are registered.
module ultrasound_array_scanner
    import ultrasound_pkg::*;
#(
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int NUM_SAMPLES    = DEF_NUM_SAMPLES,
    parameter int DIST_W         = DEF_DIST_W,
    parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset,
    ultrasound_array_scanner_if.slave bus
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int NS_W  = $clog2(NUM_SAMPLES + 1);
    localparam logic [DIST_W-1:0] DIST_MAX = '1;
    localparam logic [NUM_CH-1:0] ONE_HOT0 = {{(NUM_CH-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic [CH_W-1:0]    ch_q, ch_d, first_ch, nxt_ch;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NS_W-1:0]    nsamp_q, nsamp_d;
    logic [DIST_W-1:0]  samp_q, samp_d, best_dist_q, best_dist_d, median, half_sat;
    logic [CH_W-1:0]    best_ch_q, best_ch_d;
    logic               best_vld_q, best_vld_d;
    logic [NUM_CH-1:0]  sync1_q, sync2_q, prev_q, cmd_q, cmd_d, pwr_q, pwr_d;
    logic [CH_W+DIST_W-1:0] loc_q, loc_d;
    logic               vld_q, vld_d, done_q, done_d, busy_q, busy_d;
    logic               first_found, nxt_found, echo_lvl, echo_rise, sort_clr, sort_ins;
    logic [31:0]        half_w;

    ultrasound_median_sorter #(.NUM_SAMPLES(NUM_SAMPLES), .DIST_W(DIST_W)) u_sorter (
        .clock   (clock),
        .reset   (reset),
        .clear_i (sort_clr),
        .insert_i(sort_ins),
        .sample_i(samp_q),
        .median_o(median)
    );

    // Descending loops leave the lowest qualifying index as the final assignment
    always_comb begin
        first_found = 1'b0;
        first_ch    = '0;
        nxt_found   = 1'b0;
        nxt_ch      = '0;
        for (int i = NUM_CH-1; i >= 0; i--) begin
            if (bus.channel_mask[i]) begin
                first_found = 1'b1;
                first_ch    = CH_W'(i);
            end
            if (mask_q[i] && (i > int'(ch_q))) begin
                nxt_found = 1'b1;
                nxt_ch    = CH_W'(i);
            end
        end
    end

    assign echo_lvl  = sync2_q[ch_q];
    assign echo_rise = sync2_q[ch_q] & ~prev_q[ch_q];
    assign half_w    = 32'(cnt_q) >> 1;
    assign half_sat  = (half_w > 32'(DIST_MAX)) ? DIST_MAX : half_w[DIST_W-1:0];

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        nsamp_d     = nsamp_q;
        samp_d      = samp_q;
        best_ch_d   = best_ch_q;
        best_dist_d = best_dist_q;
        best_vld_d  = best_vld_q;
        sort_clr    = 1'b0;
        sort_ins    = 1'b0;
        case (state_q)
            S_IDLE: if (bus.calculate) begin
                mask_d      = bus.channel_mask;
                best_ch_d   = '0;
                best_dist_d = DIST_MAX;
                best_vld_d  = 1'b0;
                cnt_d       = '0;
                nsamp_d     = '0;
                sort_clr    = 1'b1;
                ch_d        = first_ch;
                state_d     = first_found ? S_POWER : S_REPORT;
            end
            S_POWER: if (cnt_q == CNT_W'(SETTLE_CYCLES-1)) begin
                cnt_d   = '0;
                state_d = S_TRIGGER;
            end else cnt_d = cnt_q + 1'b1;
            S_TRIGGER: if (cnt_q == CNT_W'(TRIG_CYCLES-1)) begin
                cnt_d   = '0;
                state_d = S_WAIT_ECHO;
            end else cnt_d = cnt_q + 1'b1;
            S_WAIT_ECHO: if (echo_rise) begin
                cnt_d   = CNT_W'(1);
                state_d = S_MEASURE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES-1)) begin
                samp_d  = DIST_MAX;
                state_d = S_STORE;
            end else cnt_d = cnt_q + 1'b1;
            S_MEASURE: if (!echo_lvl) begin
                samp_d  = half_sat;
                state_d = S_STORE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES-1)) begin
                samp_d  = DIST_MAX;
                state_d = S_STORE;
            end else cnt_d = cnt_q + 1'b1;
            S_STORE: begin
                sort_ins = 1'b1;
                cnt_d    = '0;
                if (int'(nsamp_q) + 1 < NUM_SAMPLES) begin
                    nsamp_d = nsamp_q + 1'b1;
                    state_d = S_TRIGGER;
                end else state_d = S_NEXT;
            end
            S_NEXT: begin
                if ((median < DIST_MAX) && (median < best_dist_q)) begin
                    best_ch_d   = ch_q;
                    best_dist_d = median;
                    best_vld_d  = 1'b1;
                end
                if (nxt_found) begin
                    ch_d     = nxt_ch;
                    cnt_d    = '0;
                    nsamp_d  = '0;
                    sort_clr = 1'b1;
                    state_d  = S_POWER;
                end else state_d = S_REPORT;
            end
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output registers are loaded from next-state values so they line up with state_q
    always_comb begin
        pwr_d  = (state_d inside {S_POWER, S_TRIGGER, S_WAIT_ECHO, S_MEASURE, S_STORE, S_NEXT})
                 ? (ONE_HOT0 << ch_d) : '0;
        cmd_d  = (state_d == S_TRIGGER) ? (ONE_HOT0 << ch_d) : '0;
        done_d = (state_d == S_REPORT);
        busy_d = (state_d != S_IDLE);
        loc_d  = loc_q;
        vld_d  = vld_q;
        if (state_d == S_REPORT) begin
            loc_d = best_vld_d ? {best_ch_d, best_dist_d} : '0;
            vld_d = best_vld_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            ch_q        <= '0;
            cnt_q       <= '0;
            nsamp_q     <= '0;
            samp_q      <= '0;
            best_ch_q   <= '0;
            best_dist_q <= DIST_MAX;
            best_vld_q  <= 1'b0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            cmd_q       <= '0;
            pwr_q       <= '0;
            loc_q       <= '0;
            vld_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            nsamp_q     <= nsamp_d;
            samp_q      <= samp_d;
            best_ch_q   <= best_ch_d;
            best_dist_q <= best_dist_d;
            best_vld_q  <= best_vld_d;
            sync1_q     <= bus.ultrasound_signals;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            cmd_q       <= cmd_d;
            pwr_q       <= pwr_d;
            loc_q       <= loc_d;
            vld_q       <= vld_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.ultrasound_commands = cmd_q;
    assign bus.ultrasound_power    = pwr_q;
    assign bus.rover_location      = loc_q;
    assign bus.valid_location      = vld_q;
    assign bus.done                = done_q;
    assign bus.busy                = busy_q;
    assign bus.state               = state_q;

endmodule
